// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control encodings: per-cycle stage actions, occupancy states,
// stall-vector polarity and stage index names.
package pipe_ctrl_pkg;

   typedef enum logic [2:0] {
      ACT_RESET   = 3'd0,
      ACT_FLUSH   = 3'd1,
      ACT_BUBBLE  = 3'd2,
      ACT_ADVANCE = 3'd3,
      ACT_HOLD    = 3'd4
   } act_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_HELD  = 2'd2
   } occ_e;

   localparam logic STOP   = 1'b1;
   localparam logic NOSTOP = 1'b0;

   localparam int IF  = 0;
   localparam int ID  = 1;
   localparam int EX  = 2;
   localparam int MEM = 3;
   localparam int WB  = 4;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Stage-boundary bundle: upstream controls/payload in, registered payload,
// occupancy and event statistics out.
interface pipe_stage_reg_if #(
   parameter int PAYLOAD_W = 128,
   parameter int STALL_W   = 6,
   parameter int CNT_W     = 16
);
   logic [STALL_W-1:0]   stall;
   logic                 flush;
   logic                 in_valid;
   logic [PAYLOAD_W-1:0] in_payload;
   logic                 cnt_clr;
   logic                 out_valid;
   logic [PAYLOAD_W-1:0] out_payload;
   logic [1:0]           state;
   logic [CNT_W-1:0]     bubble_cnt;
   logic [CNT_W-1:0]     hold_cnt;
   logic [CNT_W-1:0]     flush_cnt;
   logic                 hold_timeout;

   modport master (
      output stall, flush, in_valid, in_payload, cnt_clr,
      input  out_valid, out_payload, state, bubble_cnt, hold_cnt, flush_cnt, hold_timeout
   );

   modport slave (
      input  stall, flush, in_valid, in_payload, cnt_clr,
      output out_valid, out_payload, state, bubble_cnt, hold_cnt, flush_cnt, hold_timeout
   );
endinterface

// File: rtl/pipe_stage_reg_chk.sv
// Simulation checker: upstream may never stop the next stage while this one runs.
module pipe_stage_reg_chk #(
   parameter int STALL_W = 6,
   parameter int STAGE   = 2
) (
   input logic               clk,
   input logic               rst,
   input logic [STALL_W-1:0] stall
);
   // flag stall[STAGE+1] without stall[STAGE]
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(stall[STAGE+1] && !stall[STAGE]))
            else $error("illegal stall vector %b at stage %0d", stall, STAGE);
      end
   end
endmodule

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter; clear wins over a same-cycle increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);
   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
   localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] r_count;

   // count register: reset/clear to zero, otherwise increment until all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= {W{1'b0}};
      end else if (clr) begin
         r_count <= {W{1'b0}};
      end else if (inc && (r_count != CNT_MAX)) begin
         r_count <= r_count + CNT_ONE;
      end else begin
         r_count <= r_count;
      end
   end

   assign count = r_count;
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic stage-boundary register: payload/valid latch with flush, bubble and hold,
// occupancy FSM, saturating event counters and a sticky hold timeout.
module pipe_stage_reg
   import pipe_ctrl_pkg::*;
#(
   parameter int                   PAYLOAD_W   = 128,
   parameter int                   STALL_W     = 6,
   parameter int                   STAGE       = EX,
   parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = {PAYLOAD_W{1'b0}},
   parameter int                   CNT_W       = 16,
   parameter int                   HOLD_MAX    = 64
) (
   input logic               clk,
   input logic               rst,
   pipe_stage_reg_if.slave   bus
);
   localparam int               RUN_W   = $clog2(HOLD_MAX + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(HOLD_MAX);
   localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

   act_e                 w_act;
   occ_e                 r_state;
   occ_e                 w_state_nxt;
   logic                 r_valid;
   logic [PAYLOAD_W-1:0] r_payload;
   logic [RUN_W-1:0]     r_run;
   logic [RUN_W-1:0]     w_run_nxt;
   logic                 r_timeout;
   logic                 w_unused_stall;

   // action decode in priority order; an illegal stall pattern falls into ADVANCE
   always_comb begin
      w_act = ACT_HOLD;
      if (rst) begin
         w_act = ACT_RESET;
      end else if (bus.flush) begin
         w_act = ACT_FLUSH;
      end else if ((bus.stall[STAGE] == STOP) && (bus.stall[STAGE+1] == NOSTOP)) begin
         w_act = ACT_BUBBLE;
      end else if (bus.stall[STAGE] == NOSTOP) begin
         w_act = ACT_ADVANCE;
      end else begin
         w_act = ACT_HOLD;
      end
   end

   // payload/valid latch; NOP whenever the entry is not valid
   always_ff @(posedge clk) begin
      case (w_act)
         ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
            r_valid   <= 1'b0;
            r_payload <= NOP_PAYLOAD;
         end
         ACT_ADVANCE: begin
            r_valid   <= bus.in_valid;
            r_payload <= bus.in_valid ? bus.in_payload : NOP_PAYLOAD;
         end
         default: begin
            r_valid   <= r_valid;
            r_payload <= r_payload;
         end
      endcase
   end

   // occupancy state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // occupancy next state; the unused encoding drains to EMPTY
   always_comb begin
      w_state_nxt = ST_EMPTY;
      case (w_act)
         ACT_ADVANCE: w_state_nxt = bus.in_valid ? ST_FULL : ST_EMPTY;
         ACT_HOLD: begin
            case (r_state)
               ST_FULL, ST_HELD: w_state_nxt = ST_HELD;
               default:          w_state_nxt = ST_EMPTY;
            endcase
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // hold run length, saturating at HOLD_MAX, cleared by any non-hold action
   always_comb begin
      w_run_nxt = {RUN_W{1'b0}};
      if (w_act == ACT_HOLD) begin
         w_run_nxt = (r_run == RUN_MAX) ? r_run : r_run + RUN_ONE;
      end else begin
         w_run_nxt = {RUN_W{1'b0}};
      end
   end

   // run register and sticky timeout (timeout also cleared by cnt_clr)
   always_ff @(posedge clk) begin
      r_run <= w_run_nxt;
      if (rst || bus.cnt_clr) begin
         r_timeout <= 1'b0;
      end else if ((w_act == ACT_HOLD) && (w_run_nxt == RUN_MAX)) begin
         r_timeout <= 1'b1;
      end else begin
         r_timeout <= r_timeout;
      end
   end

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk(clk), .rst(rst), .clr(bus.cnt_clr),
      .inc(w_act == ACT_BUBBLE), .count(bus.bubble_cnt)
   );

   sat_counter #(.W(CNT_W)) u_hold_cnt (
      .clk(clk), .rst(rst), .clr(bus.cnt_clr),
      .inc(w_act == ACT_HOLD), .count(bus.hold_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk(clk), .rst(rst), .clr(bus.cnt_clr),
      .inc((w_act == ACT_FLUSH) && r_valid), .count(bus.flush_cnt)
   );

   pipe_stage_reg_chk #(.STALL_W(STALL_W), .STAGE(STAGE)) u_chk (
      .clk(clk), .rst(rst), .stall(bus.stall)
   );

   assign bus.out_valid    = r_valid;
   assign bus.out_payload  = r_payload;
   assign bus.state        = r_state;
   assign bus.hold_timeout = r_timeout;
   assign w_unused_stall   = ^bus.stall;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed walk through the stage behaviours followed by legal random traffic,
// all checked against a behavioural model of the stage boundary.
module tb_pipe_stage_reg;
   localparam int              PW   = 16;
   localparam int              SW   = 6;
   localparam int              STG  = 2;
   localparam int              CW   = 3;
   localparam int              HM   = 4;
   localparam logic [PW-1:0]   NOP  = 16'h0F0F;
   localparam int              CMAX = (1 << CW) - 1;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   // model state
   bit          m_valid;
   logic [15:0] m_pay;
   int          m_age;
   int          m_bub, m_hold, m_fl, m_run;
   bit          m_tmo;

   pipe_stage_reg_if #(.PAYLOAD_W(PW), .STALL_W(SW), .CNT_W(CW)) bus ();

   pipe_stage_reg #(
      .PAYLOAD_W(PW), .STALL_W(SW), .STAGE(STG),
      .NOP_PAYLOAD(NOP), .CNT_W(CW), .HOLD_MAX(HM)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic step(input bit r, input bit f, input logic [5:0] s,
                       input bit v, input logic [15:0] p, input bit c);
      int st;
      rst = r; bus.flush = f; bus.stall = s;
      bus.in_valid = v; bus.in_payload = p; bus.cnt_clr = c;
      @(posedge clk);
      if (r) begin
         m_valid = 0; m_pay = NOP; m_age = 0;
         m_bub = 0; m_hold = 0; m_fl = 0; m_run = 0; m_tmo = 0;
      end else begin
         if (f) begin
            if (m_valid) m_fl = sat(m_fl);
            m_valid = 0; m_pay = NOP; m_run = 0;
         end else if (s[STG] && !s[STG+1]) begin
            m_bub = sat(m_bub);
            m_valid = 0; m_pay = NOP; m_run = 0;
         end else if (!s[STG]) begin
            m_valid = v; m_pay = v ? p : NOP; m_age = 0; m_run = 0;
         end else begin
            m_hold = sat(m_hold);
            m_age++;
            if (m_run < HM) m_run++;
            if (m_run == HM) m_tmo = 1;
         end
         if (c) begin
            m_bub = 0; m_hold = 0; m_fl = 0; m_tmo = 0;
         end
      end
      #1;
      st = !m_valid ? 0 : ((m_age == 0) ? 1 : 2);
      chk("out_valid",    32'(bus.out_valid),    32'(m_valid));
      chk("out_payload",  32'(bus.out_payload),  32'(m_pay));
      chk("state",        32'(bus.state),        32'(st));
      chk("bubble_cnt",   32'(bus.bubble_cnt),   32'(m_bub));
      chk("hold_cnt",     32'(bus.hold_cnt),     32'(m_hold));
      chk("flush_cnt",    32'(bus.flush_cnt),    32'(m_fl));
      chk("hold_timeout", 32'(bus.hold_timeout), 32'(m_tmo));
   endtask

   initial begin
      logic [5:0] s;
      n_vec = 0; n_err = 0;
      rst = 1'b1; bus.flush = 1'b0; bus.stall = 6'b0; bus.in_valid = 1'b0;
      bus.in_payload = 16'h0; bus.cnt_clr = 1'b0;

      step(1, 0, 6'b000000, 0, 16'h0000, 0);
      step(1, 0, 6'b000000, 1, 16'h1111, 0);
      chk("reset_payload", 32'(bus.out_payload), 32'(NOP));
      chk("reset_state",   32'(bus.state),       32'd0);

      step(0, 0, 6'b000000, 1, 16'h00A5, 0);
      chk("load_payload", 32'(bus.out_payload), 32'h0000_00A5);
      chk("load_state",   32'(bus.state),       32'd1);
      for (int i = 0; i < 3; i++) step(0, 0, 6'b001100, 1, 16'hBEEF, 0);
      chk("held_payload", 32'(bus.out_payload), 32'h0000_00A5);
      chk("held_cnt",     32'(bus.hold_cnt),    32'd3);
      step(0, 0, 6'b000100, 1, 16'hBEEF, 0);
      chk("bubble_one",   32'(bus.bubble_cnt),  32'd1);

      step(0, 0, 6'b000000, 1, 16'h1234, 0);
      step(0, 1, 6'b001100, 1, 16'h5678, 0);
      chk("flush_cnt_one",  32'(bus.flush_cnt), 32'd1);
      chk("flush_hold_cnt", 32'(bus.hold_cnt),  32'd3);
      step(0, 1, 6'b000000, 1, 16'h5678, 0);
      chk("flush_empty", 32'(bus.flush_cnt), 32'd1);

      step(0, 0, 6'b000000, 1, 16'h4242, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 6'b111100, 0, 16'h0, 0);
      chk("no_timeout_yet", 32'(bus.hold_timeout), 32'd0);
      step(0, 0, 6'b111100, 0, 16'h0, 0);
      chk("timeout_set", 32'(bus.hold_timeout), 32'd1);
      step(0, 0, 6'b000000, 1, 16'h7777, 0);
      chk("timeout_sticky", 32'(bus.hold_timeout), 32'd1);
      step(0, 0, 6'b001100, 0, 16'h0, 1);
      chk("clr_timeout", 32'(bus.hold_timeout), 32'd0);
      chk("clr_hold",    32'(bus.hold_cnt),     32'd0);

      for (int i = 0; i < 9; i++) step(0, 0, 6'b000100, 1, 16'h3333, 0);
      chk("bubble_sat", 32'(bus.bubble_cnt), 32'(CMAX));
      step(0, 0, 6'b000000, 1, 16'h9999, 0);
      step(0, 0, 6'b001100, 0, 16'h0, 0);
      step(0, 0, 6'b001100, 0, 16'h0, 0);
      step(1, 0, 6'b001100, 0, 16'h0, 0);
      chk("rst_mid_hold", 32'(bus.out_valid), 32'd0);
      chk("rst_bubble",   32'(bus.bubble_cnt), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         s = 6'($urandom);
         if ($urandom_range(0, 9) < 6) s[STG] = 1'b1;
         if (s[STG+1] && !s[STG]) s[STG+1] = 1'b0;
         step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0), s,
              1'($urandom), 16'($urandom), ($urandom_range(0, 63) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
